waterlight_ahb_regs: RTL and testbench

WATERLIGHT_AHB_REGS -- requirements
Module: waterlight_ahb_regs

---
 rtl/waterlight_ahb_regs.sv | 146 ++++++++++++++
 tb/tb_waterlight_ahb_regs.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/waterlight_ahb_regs.sv
// AHB-Lite register slave for the water-light LED stage.
// Holds the pattern MODE and SPEED terminal count, counts step pulses
// returned on LEDclk, and exposes a constant ID word. Zero wait states.
`timescale 1ns/1ps

module waterlight_ahb_regs #(
    parameter logic [31:0] DEFAULT_SPEED = 32'd24_999_999,
    parameter logic [31:0] MIN_SPEED     = 32'd1
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    input  logic        LEDclk,
    output logic [7:0]  WaterLight_mode,
    output logic [31:0] WaterLight_speed
);

    localparam logic [31:0] ID_VALUE   = 32'h574C_0001;
    localparam logic [1:0]  ADDR_MODE  = 2'd0;
    localparam logic [1:0]  ADDR_SPEED = 2'd1;
    localparam logic [1:0]  ADDR_STEP  = 2'd2;
    localparam logic [1:0]  ADDR_ID    = 2'd3;

    // SPEED never drops below MIN_SPEED so the LED stage always has a
    // non-zero half period to count.
    function automatic logic [31:0] clamp_speed(input logic [31:0] value);
        logic [31:0] result;
        if (value < MIN_SPEED) begin
            result = MIN_SPEED;
        end else begin
            result = value;
        end
        return result;
    endfunction

    logic [1:0]  r_addr;
    logic        r_wr_en;
    logic        r_rd_en;
    logic [7:0]  r_mode;
    logic [31:0] r_speed;
    logic [31:0] r_step_cnt;
    logic        r_led_d;

    logic        w_xfer_qual;
    logic        w_wr_mode;
    logic        w_wr_speed;
    logic        w_wr_step;
    logic        w_led_rise;
    logic [31:0] w_rdata;
    logic        w_unused_bits;

    assign w_xfer_qual = HSEL & HREADY & HTRANS[1];
    assign w_wr_mode   = r_wr_en & (r_addr == ADDR_MODE);
    assign w_wr_speed  = r_wr_en & (r_addr == ADDR_SPEED);
    assign w_wr_step   = r_wr_en & (r_addr == ADDR_STEP);
    assign w_led_rise  = LEDclk & ~r_led_d;

    // Size and byte-lane bits are not decoded; every access is a full word.
    assign w_unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0]};

    assign HREADYOUT        = 1'b1;
    assign HRESP            = 1'b0;
    assign HRDATA           = w_rdata;
    assign WaterLight_mode  = r_mode;
    assign WaterLight_speed = r_speed;

    // Capture the address phase so the data phase knows what to access.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_addr  <= 2'd0;
            r_wr_en <= 1'b0;
            r_rd_en <= 1'b0;
        end else begin
            r_wr_en <= w_xfer_qual & HWRITE;
            r_rd_en <= w_xfer_qual & ~HWRITE;
            if (w_xfer_qual) begin
                r_addr <= HADDR[3:2];
            end else begin
                r_addr <= r_addr;
            end
        end
    end

    // Writable configuration registers, updated at the end of a write data phase.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_mode  <= 8'h01;
            r_speed <= DEFAULT_SPEED;
        end else begin
            if (w_wr_mode) begin
                r_mode <= HWDATA[7:0];
            end else begin
                r_mode <= r_mode;
            end
            if (w_wr_speed) begin
                r_speed <= clamp_speed(HWDATA);
            end else begin
                r_speed <= r_speed;
            end
        end
    end

    // Step counter: count LEDclk rising edges; a write to STEP_CNT clears it
    // and takes priority over an edge in the same cycle.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            r_led_d    <= 1'b0;
            r_step_cnt <= 32'd0;
        end else begin
            r_led_d <= LEDclk;
            if (w_wr_step) begin
                r_step_cnt <= 32'd0;
            end else if (w_led_rise) begin
                r_step_cnt <= r_step_cnt + 32'd1;
            end else begin
                r_step_cnt <= r_step_cnt;
            end
        end
    end

    // Read mux: live register value for a read data phase, zero otherwise.
    always_comb begin
        w_rdata = 32'd0;
        if (r_rd_en) begin
            case (r_addr)
                ADDR_MODE:  w_rdata = {24'd0, r_mode};
                ADDR_SPEED: w_rdata = r_speed;
                ADDR_STEP:  w_rdata = r_step_cnt;
                ADDR_ID:    w_rdata = ID_VALUE;
                default:    w_rdata = 32'd0;
            endcase
        end else begin
            w_rdata = 32'd0;
        end
    end

endmodule

// File: tb/tb_waterlight_ahb_regs.sv
// Self-checking bench for waterlight_ahb_regs: directed scenarios plus a
// randomized read/write mix checked against a register-level model.
`timescale 1ns/1ps

module tb_waterlight_ahb_regs;

    localparam logic [31:0] DEF_SPEED = 32'd24_999_999;
    localparam logic [31:0] MIN_SPD   = 32'd1;
    localparam logic [31:0] ID_WORD   = 32'h574C_0001;

    logic        clk;
    logic        clk_en;
    logic        RST;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        LEDclk;
    logic [7:0]  WaterLight_mode;
    logic [31:0] WaterLight_speed;

    int tests_run;
    int tests_failed;

    // Register-level model of the programmer-visible state.
    logic [7:0]  m_mode;
    logic [31:0] m_speed;
    logic [31:0] m_cnt;

    waterlight_ahb_regs #(
        .DEFAULT_SPEED(DEF_SPEED),
        .MIN_SPEED    (MIN_SPD)
    ) dut (
        .clk             (clk),
        .RST             (RST),
        .HSEL            (HSEL),
        .HADDR           (HADDR),
        .HTRANS          (HTRANS),
        .HWRITE          (HWRITE),
        .HSIZE           (HSIZE),
        .HWDATA          (HWDATA),
        .HREADY          (HREADY),
        .HREADYOUT       (HREADYOUT),
        .HRESP           (HRESP),
        .HRDATA          (HRDATA),
        .LEDclk          (LEDclk),
        .WaterLight_mode (WaterLight_mode),
        .WaterLight_speed(WaterLight_speed)
    );

    // Gated free-running clock so reset can be checked with no edges at all.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    function automatic void m_reset();
        m_mode  = 8'h01;
        m_speed = DEF_SPEED;
        m_cnt   = 32'd0;
    endfunction

    function automatic void m_write(input logic [31:0] addr, input logic [31:0] data);
        case (addr[3:2])
            2'd0: m_mode  = data[7:0];
            2'd1: m_speed = (data < MIN_SPD) ? MIN_SPD : data;
            2'd2: m_cnt   = 32'd0;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] addr);
        case (addr[3:2])
            2'd0:    return {24'd0, m_mode};
            2'd1:    return m_speed;
            2'd2:    return m_cnt;
            default: return ID_WORD;
        endcase
    endfunction

    task automatic bus_idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWRITE = 1'b0;
        HREADY = 1'b1;
    endtask

    // Both bus tasks start and end on a falling edge.
    task automatic ahb_write(input logic [31:0] addr, input logic [31:0] data);
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = addr;
        HSIZE = 3'b010;
        @(negedge clk);
        bus_idle();
        HWDATA = data;
        @(negedge clk);
        m_write(addr, data);
    endtask

    task automatic ahb_read(input logic [31:0] addr, output logic [31:0] data);
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = addr;
        HSIZE = 3'b010;
        @(negedge clk);
        bus_idle();
        data = HRDATA;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        clk_en = 1'b0;
        RST = 1'b1;
        #3;
        m_reset();
        tests_run++;
        if (WaterLight_mode !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_mode: got %h expected %h", WaterLight_mode, 8'h01);
        end
        tests_run++;
        if (WaterLight_speed !== DEF_SPEED) begin
            tests_failed++;
            $display("FAIL reset_speed: got %0d expected %0d", WaterLight_speed, DEF_SPEED);
        end
        tests_run++;
        if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_resp: got ready=%b resp=%b expected 1/0", HREADYOUT, HRESP);
        end
        RST = 1'b0;
        clk_en = 1'b1;
        @(negedge clk);
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_step: got %h expected 0", rd);
        end
        ahb_read(32'hC, rd);
        tests_run++;
        if (rd !== ID_WORD) begin
            tests_failed++;
            $display("FAIL reset_id: got %h expected %h", rd, ID_WORD);
        end
    endtask

    task automatic test_back_to_back();
        // Write address phase, then read address phase overlapping the write data phase.
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
        @(negedge clk);
        HWDATA = 32'h0000_0100;
        HWRITE = 1'b0; HADDR = 32'h4;
        @(negedge clk);
        m_write(32'h4, 32'h0000_0100);
        bus_idle();
        tests_run++;
        if (HRDATA !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL b2b_rdata: got %h expected %h", HRDATA, 32'h0000_0100);
        end
        tests_run++;
        if (WaterLight_speed !== 32'h0000_0100) begin
            tests_failed++;
            $display("FAIL b2b_speed: got %h expected %h", WaterLight_speed, 32'h0000_0100);
        end
        @(negedge clk);
    endtask

    task automatic test_clamp();
        logic [31:0] rd;
        ahb_write(32'h4, 32'd0);
        ahb_read(32'h4, rd);
        tests_run++;
        if (rd !== 32'd1) begin
            tests_failed++;
            $display("FAIL clamp_speed: got %h expected 1", rd);
        end
        ahb_write(32'h0, 32'hFFFF_FF02);
        ahb_read(32'h0, rd);
        tests_run++;
        if (rd !== 32'h0000_0002 || WaterLight_mode !== 8'h02) begin
            tests_failed++;
            $display("FAIL mode_trunc: got %h/%h expected 00000002/02", rd, WaterLight_mode);
        end
    endtask

    task automatic test_step_count();
        logic [31:0] rd;
        ahb_write(32'h8, 32'h0);
        for (int i = 0; i < 5; i++) begin
            LEDclk = 1'b0;
            @(negedge clk);
            LEDclk = 1'b1;
            @(negedge clk);
            m_cnt = m_cnt + 32'd1;
        end
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd5) begin
            tests_failed++;
            $display("FAIL step_five: got %0d expected 5", rd);
        end
        repeat (10) @(negedge clk);
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== m_cnt) begin
            tests_failed++;
            $display("FAIL step_hold: got %0d expected %0d", rd, m_cnt);
        end
        LEDclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_clear_collision();
        logic [31:0] rd;
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h8;
        @(negedge clk);
        bus_idle();
        HWDATA = $urandom;
        LEDclk = 1'b1;
        @(negedge clk);
        m_cnt = 32'd0;
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL clear_wins: got %0d expected 0", rd);
        end
        LEDclk = 1'b0;
        @(negedge clk);
        LEDclk = 1'b1;
        @(negedge clk);
        m_cnt = m_cnt + 32'd1;
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd1) begin
            tests_failed++;
            $display("FAIL clear_next: got %0d expected 1", rd);
        end
        LEDclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wrap();
        logic [31:0] rd;
        force dut.r_step_cnt = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.r_step_cnt;
        LEDclk = 1'b1;
        @(negedge clk);
        m_cnt = 32'd0;
        ahb_read(32'h8, rd);
        tests_run++;
        if (rd !== 32'd0) begin
            tests_failed++;
            $display("FAIL step_wrap: got %h expected 0", rd);
        end
        LEDclk = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] rd;
        logic [31:0] exp;
        int          bad;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            addr = ($urandom & 32'hFFFF_FFF3) | ({30'd0, 2'($urandom_range(0, 3))} << 2);
            data = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 1) == 0) begin
                ahb_write(addr, data);
            end else begin
                exp = m_read(addr);
                ahb_read(addr, rd);
                if (rd !== exp) begin
                    bad++;
                    $display("FAIL random_read[%0d]: addr %h got %h expected %h", i, addr, rd, exp);
                end
            end
            if (WaterLight_mode !== m_mode || WaterLight_speed !== m_speed) begin
                bad++;
                $display("FAIL random_outputs[%0d]: got %h/%h expected %h/%h",
                         i, WaterLight_mode, WaterLight_speed, m_mode, m_speed);
            end
        end
        tests_run++;
        if (bad != 0) tests_failed++;
    endtask

    task automatic test_unqualified();
        logic [31:0] rd;
        for (int v = 0; v < 3; v++) begin
            HSEL   = (v == 0) ? 1'b0 : 1'b1;
            HTRANS = (v == 1) ? 2'b00 : 2'b10;
            HREADY = (v == 2) ? 1'b0 : 1'b1;
            HWRITE = 1'b1;
            HADDR  = 32'h4 + 32'(v % 2) * 32'h4;
            @(negedge clk);
            bus_idle();
            HWDATA = 32'hDEAD_0000 | 32'(v);
            @(negedge clk);
            ahb_read(32'h4, rd);
            tests_run++;
            if (rd !== m_speed || WaterLight_mode !== m_mode) begin
                tests_failed++;
                $display("FAIL unqual_%0d: got speed %h mode %h expected %h %h",
                         v, rd, WaterLight_mode, m_speed, m_mode);
            end
        end
        ahb_write(32'hC, 32'h1234_5678);
        ahb_read(32'hC, rd);
        tests_run++;
        if (rd !== ID_WORD) begin
            tests_failed++;
            $display("FAIL id_write: got %h expected %h", rd, ID_WORD);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] rd;
        ahb_write(32'h0, 32'h0000_0004);
        HSEL = 1'b1; HREADY = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h4;
        @(negedge clk);
        bus_idle();
        HWDATA = 32'h0000_1234;
        #2;
        RST = 1'b1;
        #1;
        m_reset();
        tests_run++;
        if (WaterLight_speed !== DEF_SPEED || HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin
            tests_failed++;
            $display("FAIL rst_mid_async: got speed %0d ready %b resp %b expected %0d 1 0",
                     WaterLight_speed, HREADYOUT, HRESP, DEF_SPEED);
        end
        @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        ahb_read(32'h4, rd);
        tests_run++;
        if (rd !== DEF_SPEED || WaterLight_mode !== 8'h01) begin
            tests_failed++;
            $display("FAIL rst_mid_after: got speed %h mode %h expected %h 01",
                     rd, WaterLight_mode, DEF_SPEED);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        clk = 1'b0;
        clk_en = 1'b0;
        RST = 1'b0;
        LEDclk = 1'b0;
        HADDR = 32'd0;
        HWDATA = 32'd0;
        HSIZE = 3'b010;
        bus_idle();
        m_reset();

        test_reset();
        test_step_count();
        test_clear_collision();
        test_wrap();
        test_back_to_back();
        test_clamp();
        test_random();
        test_unqualified();
        test_reset_mid_write();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
